// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side drain engine.
package fifo_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} drain_state_t;
  localparam int FIFO_DATA_W = 8;
endpackage

// File: rtl/fifo_skid_buf.sv
// Ring skid buffer: DEPTH entries, push at tail, pop at head, head word always visible.
// Storage is reset to zero so the head output reads 0 out of reset.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head_data,
  output logic [OW-1:0]     occ
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PW-1:0]                hd, tl;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy; push+pop on one edge leaves occ unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
      hd  <= '0;
      tl  <= '0;
      occ <= '0;
    end else begin
      if (push) begin
        mem[tl] <= din;
        tl      <= nxt(tl);
      end
      if (pop) hd <= nxt(hd);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  assign head_data = mem[hd];

`ifndef SYNTHESIS
  // The credit check upstream must keep the ring from ever overflowing or underflowing.
  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && occ == OW'(DEPTH)));
  underflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(pop && occ == '0));
`endif

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side engine for the 16x8 sync FIFO: issues reads, absorbs the 1-cycle read latency
// in a skid buffer and re-emits words on a valid/ready stream at one word per clock.
// Optional macro STATS_EN adds the pop_cnt port and handshake counter.
module fifo_drain_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W     = FIFO_DATA_W,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy
`ifdef STATS_EN
  ,
  output logic [CNT_W-1:0]  pop_cnt
`endif
);

  localparam int OW = $clog2(SKID_DEPTH + 1);
  localparam int CW = OW + 1;

  drain_state_t  state;
  logic          inflight;
  logic          pop;
  logic [OW-1:0] occ;
  logic [CW-1:0] used;

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;

  // Slots committed after this edge; counting the pop here keeps sustained flow bubble-free.
  assign used    = CW'(occ) + CW'(inflight) - CW'(pop);
  assign fifo_rd = (state == RUN) && !fifo_empty && (used < CW'(SKID_DEPTH));

  assign busy    = (state != IDLE) || inflight || m_valid;

  // Run/stop FSM; DRAIN waits for the in-flight word and the buffer to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= DRAIN;
        DRAIN:   if (en) state <= RUN;
                 else if (!inflight && occ == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // An accepted read returns data next cycle; fifo_rd already implies !fifo_empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= fifo_rd;
  end

  fifo_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .pop       (pop),
    .din       (fifo_dout),
    .head_data (m_data),
    .occ       (occ)
  );

`ifdef STATS_EN
  // Free-running count of stream handshakes, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      pop_cnt <= '0;
    else if (pop) pop_cnt <= pop_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural 16x8 FIFO model on the read side.
module tb_fifo_drain_ctrl;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, m_ready = 1'b0;
  logic       fifo_rd, fifo_empty, m_valid, busy;
  logic [7:0] fifo_dout, m_data;
`ifdef STATS_EN
  logic [15:0] pop_cnt;
`endif

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  fifo_drain_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy)
`ifdef STATS_EN
    ,
    .pop_cnt    (pop_cnt)
`endif
  );

  // FIFO model: preload sets 16 words base..base+15; reads return data the next cycle.
  logic       frst = 1'b1, pre_go = 1'b0;
  logic [7:0] pre_base = 8'h00;
  logic [7:0] fm [16];
  logic [4:0] fcnt;
  logic [3:0] frp;

  always @(posedge clk or posedge frst) begin
    if (frst) begin
      fcnt <= 5'd0; frp <= 4'd0; fifo_dout <= 8'h00;
    end else if (pre_go) begin
      for (int i = 0; i < 16; i++) fm[i] <= pre_base + 8'(i);
      fcnt <= 5'd16; frp <= 4'd0;
    end else if (fifo_rd && fcnt != 5'd0) begin
      fifo_dout <= fm[frp]; frp <= frp + 4'd1; fcnt <= fcnt - 5'd1;
    end
  end
  assign fifo_empty = (fcnt == 5'd0);

  // Stream monitor with cycle stamps.
  int         cyc = 0;
  logic [7:0] rx  [256];
  int         rxc [256];
  int         rx_n = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_valid && m_ready) begin
      rx[rx_n]  <= m_data;
      rxc[rx_n] <= cyc;
      rx_n      <= rx_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic preload(input logic [7:0] base);
    pre_base = base; pre_go = 1'b1;
    @(negedge clk);
    pre_go = 1'b0;
  endtask

  task automatic wait_cnt(input int b, input int n, input int budget);
    for (int i = 0; i < budget && (rx_n - b) < n; i++) @(negedge clk);
  endtask

  function automatic int order_errs(input int b, input int n, input logic [7:0] base);
    int e = 0;
    for (int i = 0; i < n; i++) if (rx[b + i] !== base + 8'(i)) e++;
    return e;
  endfunction

  initial begin
    int b, k0, bad;
    #2 frst = 1'b0;
    // Reset with en=1 and a non-empty FIFO.
    en = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    preload(8'h10);
    #1;
    chk("rst_fifo_nonempty", fifo_empty, 1'b0);
    chk("rst_fifo_rd", fifo_rd, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
`ifdef STATS_EN
    chk("rst_pop_cnt", pop_cnt, 16'd0);
`endif

    // Burst: 16 words back-to-back after startup.
    @(negedge clk);
    rst = 1'b0; k0 = cyc; b = rx_n;
    wait_cnt(b, 16, 100);
    chk("burst_count", rx_n - b, 16);
    chk("burst_order", order_errs(b, 16, 8'h10), 0);
    chk("burst_latency", rxc[b] - k0, 3);
    chk("burst_back_to_back", rxc[b + 15] - rxc[b], 15);
    chk("burst_rd_low_empty", fifo_rd, 1'b0);
    chk("burst_busy_run", busy, 1'b1);
`ifdef STATS_EN
    chk("burst_pop_cnt", pop_cnt, 16'd16);
`endif
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk("burst_idle_busy", busy, 1'b0);

    // Same-edge capture+pop, then backpressure mid-burst.
    preload(8'h20);
    b = rx_n; en = 1'b1; m_ready = 1'b1;
    wait_cnt(b, 2, 40);
    chk("same_occ", dut.occ, 1);
    chk("same_inflight", dut.inflight, 1'b1);
    chk("same_rd", fifo_rd, 1'b1);
    @(negedge clk);
    chk("same_occ_next", dut.occ, 1);
    chk("same_rd_next", fifo_rd, 1'b1);
    @(negedge clk);
    chk("bp_count_at_stall", rx_n - b, 4);
    m_ready = 1'b0; bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (m_valid !== 1'b1 || m_data !== 8'h24 || fifo_rd !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("bp_hold", bad, 0);
    chk("bp_occ_full", dut.occ, 2);
    chk("bp_no_pops", rx_n - b, 4);
    m_ready = 1'b1;
    wait_cnt(b, 16, 100);
    repeat (3) @(negedge clk);
    chk("bp_count", rx_n - b, 16);
    chk("bp_order", order_errs(b, 16, 8'h20), 0);
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_idle_busy", busy, 1'b0);

    // Stop while a read is in flight and one word is buffered.
    preload(8'h30);
    b = rx_n; en = 1'b1;
    wait_cnt(b, 3, 40);
    en = 1'b0;
    @(negedge clk);
    chk("stop_rd_off", fifo_rd, 1'b0);
    chk("stop_occ", dut.occ, 1);
    chk("stop_inflight", dut.inflight, 1'b1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fifo_rd !== 1'b0) bad++;
    end
    chk("stop_no_rd", bad, 0);
    chk("stop_words", rx_n - b, 6);
    chk("stop_order", order_errs(b, 6, 8'h30), 0);
    chk("stop_fifo_left", fcnt, 5'd10);
    chk("stop_busy", busy, 1'b0);

    // Mid-operation reset with a full buffer; restart sees only fresh data.
    m_ready = 1'b0; en = 1'b1; bad = 1;
    for (int i = 0; i < 20 && bad != 0; i++) begin
      @(negedge clk);
      if (dut.occ == 2) bad = 0;
    end
    chk("mrst_reached_full", bad, 0);
    rst = 1'b1; frst = 1'b1;
    #1;
    chk("mrst_m_valid", m_valid, 1'b0);
    chk("mrst_m_data", m_data, 8'h00);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_fifo_rd", fifo_rd, 1'b0);
    @(negedge clk);
    rst = 1'b0; frst = 1'b0;
    preload(8'h40);
    b = rx_n; m_ready = 1'b1;
    wait_cnt(b, 16, 100);
    repeat (3) @(negedge clk);
    chk("mrst_count", rx_n - b, 16);
    chk("mrst_order", order_errs(b, 16, 8'h40), 0);
`ifdef STATS_EN
    chk("mrst_pop_cnt", pop_cnt, 16'd16);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
